// File: rtl/uart_finish_monitor.sv
// 8N1 UART receive monitor with marker-sequence and watchdog finish detection.
// Decoded bytes feed a sticky finish flag used to stop a simulation run.
module uart_finish_monitor #(
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter int unsigned MARKER_LEN     = 4,
  parameter logic [63:0] MARKER         = 64'h444F4E45,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       serial_rx,
  input  logic       enable,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       marker_seen,
  output logic       timeout,
  output logic       finish
);

  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  MLEN = 4'(MARKER_LEN);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam bit          WD_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        sync1_q, s_rx_q;
  logic        byte_ok, stop_bad, tick;

  logic [7:0]  rx_data_q;
  logic        rx_valid_q, ferr_q;
  logic        marker_q, timeout_q, finish_q;
  logic [31:0] wd_q;

  logic [7:0]  hist_q [MARKER_LEN];
  logic [7:0]  hist_d [MARKER_LEN];
  logic [3:0]  fill_q, fill_d;
  logic        match;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q <= 1'b1;
      s_rx_q  <= 1'b1;
    end else begin
      sync1_q <= serial_rx;
      s_rx_q  <= sync1_q;
    end
  end

  assign tick = (cnt_q == 16'd0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    byte_ok  = 1'b0;
    stop_bad = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!s_rx_q) begin
          cnt_d   = HALF;
          state_d = S_START;
        end
      end
      S_START: begin
        if (!tick) begin
          cnt_d = cnt_q - 16'd1;
        end else if (!s_rx_q) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          cnt_d   = FULL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          shift_d = {s_rx_q, shift_q[7:1]};
          cnt_d   = FULL;
          if (bit_q == 3'd7) state_d = S_STOP;
          else bit_d = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - 16'd1;
        end else if (s_rx_q) begin
          byte_ok = 1'b1;
          state_d = S_IDLE;
        end else begin
          stop_bad = 1'b1;
          state_d  = S_BREAK;
        end
      end
      S_BREAK: begin
        if (s_rx_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_valid_q <= byte_ok;
      ferr_q     <= stop_bad;
      if (byte_ok) rx_data_q <= shift_q;
    end
  end

  // hist_d[0] is the newest byte; match only once enough bytes arrived
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    match  = 1'b0;
    if (rx_valid_q) begin
      hist_d[0] = rx_data_q;
      for (int i = 1; i < int'(MARKER_LEN); i++) hist_d[i] = hist_q[i-1];
      if (fill_q < MLEN) fill_d = fill_q + 4'd1;
      match = (fill_d == MLEN);
      for (int i = 0; i < int'(MARKER_LEN); i++)
        if (hist_d[i] != MARKER[8*i +: 8]) match = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < int'(MARKER_LEN); i++) hist_q[i] <= 8'd0;
      fill_q   <= 4'd0;
      marker_q <= 1'b0;
    end else begin
      if (stop_bad) begin
        for (int i = 0; i < int'(MARKER_LEN); i++) hist_q[i] <= 8'd0;
        fill_q <= 4'd0;
      end else begin
        hist_q <= hist_d;
        fill_q <= fill_d;
      end
      if (match) marker_q <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wd_q      <= 32'd0;
      timeout_q <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      if (WD_EN && enable && !timeout_q) begin
        if (wd_q == WD_LAST) timeout_q <= 1'b1;
        else wd_q <= wd_q + 32'd1;
      end
      finish_q <= marker_q | timeout_q;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = ferr_q;
  assign marker_seen = marker_q;
  assign timeout     = timeout_q;
  assign finish      = finish_q;

endmodule

// File: tb/tb_uart_finish_monitor.sv
// Bench for uart_finish_monitor: frame tables, corner sequences,
// watchdog timing and randomized frames against a byte-level model.
module tb_uart_finish_monitor;

  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, rx = 1'b1, en = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_error, marker_seen, timeout, finish;

  logic       wrst = 1'b1, wen = 1'b0, wrx = 1'b1;
  logic [7:0] w_data;
  logic       w_valid, w_fe, w_ms, w_to, w_fin;

  uart_finish_monitor #(
    .CLKS_PER_BIT(CPB), .MARKER_LEN(4),
    .MARKER(64'h444F4E45), .TIMEOUT_CYCLES(0)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .serial_rx(rx), .enable(en),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_error(frame_error),
    .marker_seen(marker_seen), .timeout(timeout), .finish(finish)
  );

  uart_finish_monitor #(
    .CLKS_PER_BIT(CPB), .MARKER_LEN(4),
    .MARKER(64'h444F4E45), .TIMEOUT_CYCLES(100)
  ) wdt (
    .sys_clk(clk), .sys_rst(wrst), .serial_rx(wrx), .enable(wen),
    .rx_data(w_data), .rx_valid(w_valid), .frame_error(w_fe),
    .marker_seen(w_ms), .timeout(w_to), .finish(w_fin)
  );

  int nvec = 0, nmis = 0;
  int cyc = 0, vcnt = 0, fcnt = 0, both = 0, vlong = 0;
  int vcyc = 0, mcyc = 0, fcyc = 0;
  logic [7:0] last_data = 8'h00;
  logic pv = 1'b0, pm = 1'b0, pf = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rx_valid) begin
      vcnt <= vcnt + 1;
      last_data <= rx_data;
      vcyc <= cyc;
    end
    if (frame_error) fcnt <= fcnt + 1;
    if (rx_valid && frame_error) both <= both + 1;
    if (rx_valid && pv) vlong <= vlong + 1;
    if (marker_seen && !pm) mcyc <= cyc;
    if (finish && !pf) fcyc <= cyc;
    pv <= rx_valid;
    pm <= marker_seen;
    pf <= finish;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("reset_outs", 32'({rx_data, rx_valid, frame_error,
        marker_seen, timeout, finish}), 32'd0);
  endtask

  task automatic send(input logic [7:0] d, input bit ok);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  typedef struct {
    bit         rst;
    logic [7:0] d;
    bit         ok;
    bit         ev;
    bit         ef;
    bit         em;
  } vec_t;

  vec_t tbl[$];

  task automatic apply(input vec_t v);
    int v0, f0;
    logic mprev;
    if (v.rst) do_reset();
    v0 = vcnt;
    f0 = fcnt;
    mprev = marker_seen;
    send(v.d, v.ok);
    chk("valid_cnt", 32'(vcnt - v0), 32'(v.ev));
    if (v.ev) chk("rx_data", 32'(last_data), 32'(v.d));
    chk("ferr_cnt", 32'(fcnt - f0), 32'(v.ef));
    chk("marker", 32'(marker_seen), 32'(v.em));
    chk("finish", 32'(finish), 32'(v.em));
    if (v.em && !mprev) begin
      chk("marker_lat", 32'(mcyc - vcyc), 32'd1);
      chk("finish_lat", 32'(fcyc - mcyc), 32'd1);
    end
  endtask

  function automatic logic [7:0] pick(input logic [7:0] prev);
    logic [7:0] alpha [4];
    int k;
    alpha = '{8'h44, 8'h4F, 8'h4E, 8'h45};
    k = int'($urandom_range(0, 3));
    if ($urandom_range(0, 9) < 6) begin
      for (int i = 0; i < 4; i++) if (alpha[i] == prev) k = (i + 1) % 4;
    end
    return alpha[k];
  endfunction

  initial begin
    int v0, f0;
    logic [7:0] q[$];
    logic [7:0] d, prev;
    bit ok, mk, em;

    // Watchdog: 50 enabled, 30 held, then enabled until the 100th edge
    repeat (2) @(negedge clk);
    wrst = 1'b0;
    chk("wd_reset", 32'(w_to), 32'd0);
    wen = 1'b1;
    repeat (50) @(negedge clk);
    wen = 1'b0;
    repeat (30) @(negedge clk);
    chk("wd_hold", 32'(w_to), 32'd0);
    wen = 1'b1;
    repeat (49) @(negedge clk);
    chk("wd_99", 32'(w_to), 32'd0);
    @(negedge clk);
    chk("wd_100", 32'(w_to), 32'd1);
    chk("wd_fin_lag", 32'(w_fin), 32'd0);
    @(negedge clk);
    chk("wd_fin", 32'(w_fin), 32'd1);
    chk("wd_marker", 32'(w_ms), 32'd0);

    tbl.push_back('{1, 8'h41, 1, 1, 0, 0});
    tbl.push_back('{0, 8'hA5, 1, 1, 0, 0});
    tbl.push_back('{1, 8'h78, 1, 1, 0, 0});
    tbl.push_back('{0, 8'h44, 1, 1, 0, 0});
    tbl.push_back('{0, 8'h4F, 1, 1, 0, 0});
    tbl.push_back('{0, 8'h4E, 1, 1, 0, 0});
    tbl.push_back('{0, 8'h45, 1, 1, 0, 1});
    tbl.push_back('{0, 8'h00, 1, 1, 0, 1});
    tbl.push_back('{1, 8'h44, 1, 1, 0, 0});
    tbl.push_back('{0, 8'h4F, 1, 1, 0, 0});
    tbl.push_back('{0, 8'h4E, 0, 0, 1, 0});
    tbl.push_back('{0, 8'h4E, 1, 1, 0, 0});
    tbl.push_back('{0, 8'h45, 1, 1, 0, 0});
    tbl.push_back('{0, 8'h44, 1, 1, 0, 0});
    tbl.push_back('{0, 8'h4F, 1, 1, 0, 0});
    tbl.push_back('{0, 8'h4E, 1, 1, 0, 0});
    tbl.push_back('{0, 8'h45, 1, 1, 0, 1});
    tbl.push_back('{1, 8'h44, 1, 1, 0, 0});
    tbl.push_back('{0, 8'h4F, 1, 1, 0, 0});
    tbl.push_back('{0, 8'h4E, 1, 1, 0, 0});
    tbl.push_back('{1, 8'h45, 1, 1, 0, 0});
    tbl.push_back('{0, 8'hDD, 1, 1, 0, 0});
    tbl.push_back('{0, 8'h44, 1, 1, 0, 0});
    tbl.push_back('{0, 8'h44, 1, 1, 0, 0});
    tbl.push_back('{0, 8'h4F, 1, 1, 0, 0});
    tbl.push_back('{0, 8'h4E, 1, 1, 0, 0});
    tbl.push_back('{0, 8'h45, 1, 1, 0, 1});
    foreach (tbl[i]) apply(tbl[i]);

    // Glitch shorter than half a bit must not start a frame
    do_reset();
    v0 = vcnt;
    f0 = fcnt;
    @(negedge clk) rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_valid", 32'(vcnt - v0), 32'd0);
    chk("glitch_ferr", 32'(fcnt - f0), 32'd0);
    apply('{0, 8'h5A, 1, 1, 0, 0});

    // Reset in the middle of the data bits of 0x33
    apply('{0, 8'h44, 1, 1, 0, 0});
    v0 = vcnt;
    f0 = fcnt;
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("midrst_outs", 32'({rx_data, rx_valid, frame_error,
        marker_seen, timeout, finish}), 32'd0);
    repeat (12 * CPB) @(negedge clk);
    chk("midrst_valid", 32'(vcnt - v0), 32'd0);
    chk("midrst_ferr", 32'(fcnt - f0), 32'd0);
    apply('{0, 8'h4F, 1, 1, 0, 0});
    apply('{0, 8'h44, 1, 1, 0, 0});
    apply('{0, 8'h4F, 1, 1, 0, 0});
    apply('{0, 8'h4E, 1, 1, 0, 0});
    apply('{0, 8'h45, 1, 1, 0, 1});

    // Randomized frames against a byte-history model
    prev = 8'h45;
    mk = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (n % 12 == 0) begin
        do_reset();
        q.delete();
        mk = 1'b0;
      end
      d = pick(prev);
      prev = d;
      ok = ($urandom_range(0, 9) != 0);
      if (ok) begin
        q.push_back(d);
        if (q.size() >= 4 && q[q.size()-4] == 8'h44 &&
            q[q.size()-3] == 8'h4F && q[q.size()-2] == 8'h4E &&
            q[q.size()-1] == 8'h45) mk = 1'b1;
      end else begin
        q.delete();
      end
      em = mk;
      apply('{0, d, ok, ok, !ok, em});
    end

    repeat (20000) @(negedge clk);
    chk("no_timeout", 32'(timeout), 32'd0);
    chk("valid_ferr_overlap", 32'(both), 32'd0);
    chk("valid_width", 32'(vlong), 32'd0);
    chk("wd_sticky", 32'({w_to, w_fin}), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/uart_finish_monitor.md
Name: uart_finish_monitor

Overview:
Simulation-side monitor on the tester's UART TX line (serial_tx of the DDR5 tester top, driven into this block's serial_rx). It decodes 8N1 frames and exposes each received byte. It asserts a sticky finish when a configured marker byte sequence arrives or a watchdog cycle budget expires. The finish output drives the bench's $finish check.

Parameters:
CLKS_PER_BIT, 868, sys_clk cycles per UART bit (100 MHz / 115200); legal range 4..65535
MARKER_LEN, 4, number of bytes in the finish marker; legal range 1..8
MARKER, 64'h444F4E45 ("DONE"), marker bytes; the last received byte is compared against MARKER[7:0], earlier bytes against higher bytes; only the low MARKER_LEN*8 bits are used
TIMEOUT_CYCLES, 0, watchdog limit in sys_clk cycles; 0 disables the watchdog; 32-bit counter

Ports:
sys_clk  input  1  system clock
sys_rst  input  1  synchronous, active-high reset
serial_rx  input  1  UART line from the device; idles high
enable  input  1  gates the watchdog counter only; decoding is always active
rx_data  output  8  last received byte; valid while rx_valid is high
rx_valid  output  1  one-cycle pulse per good frame
frame_error  output  1  one-cycle pulse when the stop bit samples low
marker_seen  output  1  sticky; set when the marker matches
timeout  output  1  sticky; set when the watchdog expires
finish  output  1  sticky; equals marker_seen OR timeout, registered

Behaviour:
- Reset (sys_rst sampled high on a sys_clk edge): rx_data=0, rx_valid=0, frame_error=0, marker_seen=0, timeout=0, finish=0. Synchronizer flops are set to 1 (idle). Byte history is cleared. Watchdog counter is 0. FSM goes to IDLE. Reset aborts any frame in progress; the following frame is decoded normally.
- Input: serial_rx passes through a 2-flop synchronizer. All decoding uses the synchronized value s_rx.
- FSM states:
  - IDLE: on s_rx=0, load bit counter = CLKS_PER_BIT/2 - 1 and go to START.
  - START: at count 0, sample s_rx. If 0, go to DATA with bit index 0 and count CLKS_PER_BIT-1. If 1, treat as a glitch and return to IDLE with no output.
  - DATA: at each count 0, shift s_rx in LSB-first and reload CLKS_PER_BIT-1. After bit 7, go to STOP.
  - STOP: at count 0, sample s_rx.
    - If 1: set rx_data, pulse rx_valid on the next cycle, and go to IDLE.
    - If 0: pulse frame_error, clear the byte history, and go to BREAK.
  - BREAK: wait for s_rx=1, then go to IDLE.
- Latency: rx_valid rises 1 cycle after the mid-stop sample, i.e. about 9.5 bit times + 3 cycles after the start falling edge.
- Marker matcher:
  - Keep a MARKER_LEN-byte shift history that is updated only on rx_valid.
  - Compare uses the new byte. marker_seen sets the cycle after an rx_valid whose byte completes the match.
  - Overlapping matches are allowed, e.g. "DDONE" matches.
  - A frame_error clears the history, so a marker split by a bad frame does not match.
- Watchdog:
  - Active only when TIMEOUT_CYCLES≠0. Counts while enable=1 and timeout=0; holds while enable=0.
  - When the count reaches TIMEOUT_CYCLES-1 on an enabled cycle, timeout sets on the next edge. The counter saturates.
- finish = registered (marker_seen | timeout); it rises one cycle after either flag. All sticky flags clear only on sys_rst.
- If marker_seen and timeout would set on the same cycle, both set.
- Decoding continues after finish; rx_valid and frame_error keep pulsing.
- rx_valid and frame_error are never high on the same cycle.

Test Plan:
- CLKS_PER_BIT=16: send 0x41 then 0xA5 at 16 cycles/bit -> rx_valid pulses exactly twice, rx_data=0x41 then 0xA5, frame_error never asserts, finish stays 0.
- Send "xDONE" (0x78,0x44,0x4F,0x4E,0x45) -> marker_seen=1 one cycle after the 5th rx_valid, finish=1 one cycle later, timeout=0. Then send 0x00 -> rx_valid still pulses.
- Send "DO", then a frame with stop bit low, then "NE" -> frame_error pulses once, marker_seen stays 0. Then send "DONE" -> marker_seen=1.
- Glitch test: hold serial_rx low for 5 cycles, then high -> no rx_valid and no frame_error; FSM back in IDLE; the following frame 0x5A decodes correctly.
- TIMEOUT_CYCLES=100, enable=1 for 50 cycles, 0 for 30, then 1 -> timeout=1 on the 100th enabled cycle edge, finish=1 one cycle later. With TIMEOUT_CYCLES=0 -> timeout never sets in 10^5 cycles.
- Assert sys_rst for 1 cycle mid-DATA of byte 0x33, then send "DONE" -> the partial byte is discarded (no rx_valid), all outputs are 0 after reset, and marker_seen sets after "DONE".
